// File: rtl/ram_prog_ctrl_if.sv
// Bus bundle for ram_prog_ctrl: CPU strobes, clear request and the program-load stream.
// The master side is the CPU/loader and the slave side is the memory controller.
interface ram_prog_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] q;
  logic              q_valid;
  logic              busy;
  logic              clr_req;
  logic              prog_en;
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_last;
  logic              prog_done;

  modport master (
    output we, re, addr, data_in, clr_req, prog_en, prog_valid, prog_data, prog_last,
    input  q, q_valid, busy, prog_done
  );

  modport slave (
    input  we, re, addr, data_in, clr_req, prog_en, prog_valid, prog_data, prog_last,
    output q, q_valid, busy, prog_done
  );
endinterface

// File: rtl/ram_prog_ctrl.sv
// Single-port main memory with a registered read, a hardware clear sequencer and a
// sequential program-load port. The memory array itself is never reset.
module ram_prog_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  ram_prog_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_PROG  = 2'd2;

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

  logic [1:0]        state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [DATA_W-1:0] q_r;
  logic              q_valid_r;
  logic              busy_r;
  logic              prog_done_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              prog_accept_s;
  logic              prog_finish_s;

  assign bus.q         = q_r;
  assign bus.q_valid   = q_valid_r;
  assign bus.busy      = busy_r;
  assign bus.prog_done = prog_done_r;

  // Write-port mux: CPU write in IDLE, zero fill in CLEAR, stream byte in PROG.
  always_comb begin
    prog_accept_s = bus.prog_en & bus.prog_valid;
    prog_finish_s = prog_accept_s & (bus.prog_last | (ptr_r == PTR_LAST));
    mem_we_s      = 1'b0;
    mem_waddr_s   = ptr_r;
    mem_wdata_s   = {DATA_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (!bus.clr_req && !bus.prog_en && bus.we) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = bus.addr;
          mem_wdata_s = bus.data_in;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      ST_CLEAR: begin
        mem_we_s = 1'b1;
      end
      ST_PROG: begin
        if (prog_accept_s) begin
          mem_we_s    = 1'b1;
          mem_wdata_s = bus.prog_data;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Memory array write; a reset edge suppresses the write so an aborted sequence stops cleanly.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Sequencer state, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= PTR_ZERO;
      q_r         <= {DATA_W{1'b0}};
      q_valid_r   <= 1'b0;
      busy_r      <= 1'b0;
      prog_done_r <= 1'b0;
    end else begin
      prog_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.clr_req) begin
            state_r   <= ST_CLEAR;
            ptr_r     <= PTR_ZERO;
            busy_r    <= 1'b1;
            q_valid_r <= 1'b0;
          end else if (bus.prog_en) begin
            state_r   <= ST_PROG;
            ptr_r     <= PTR_ZERO;
            busy_r    <= 1'b1;
            q_valid_r <= 1'b0;
          end else if (bus.we) begin
            q_valid_r <= 1'b0;
          end else if (bus.re) begin
            q_r       <= mem_r[bus.addr];
            q_valid_r <= 1'b1;
          end else begin
            q_valid_r <= 1'b0;
          end
        end
        ST_CLEAR: begin
          q_valid_r <= 1'b0;
          if (ptr_r == PTR_LAST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            ptr_r <= ptr_r + PTR_ONE;
          end
        end
        ST_PROG: begin
          q_valid_r <= 1'b0;
          if (!bus.prog_en) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (prog_finish_s) begin
            // Pointer is left at the last written word; it never wraps to 0.
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            prog_done_r <= 1'b1;
          end else if (prog_accept_s) begin
            ptr_r <= ptr_r + PTR_ONE;
          end else begin
            ptr_r <= ptr_r;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          q_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_prog_ctrl.sv
// Self-checking bench for ram_prog_ctrl: directed vectors, multi-cycle sequences and
// randomized traffic compared each cycle against a behavioural memory model.
module tb_ram_prog_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ram_prog_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus_if ();

  ram_prog_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired act=running req=finished");
    $fatal(1, "watchdog");
  end

  // Reference model: memory contents plus the observable outputs.
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_q       = 8'h00;
  logic       m_qv      = 1'b0;
  logic       m_busy    = 1'b0;
  logic       m_done    = 1'b0;
  int         clear_left = 0;
  bit         loading    = 1'b0;
  int         load_idx   = 0;

  function void model_edge();
    if (rst) begin
      clear_left = 0; loading = 1'b0;
      m_q = 8'h00; m_qv = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (clear_left > 0) begin
      m_mem[DEPTH - clear_left] = 8'h00;
      clear_left--;
      m_busy = (clear_left != 0);
      m_qv   = 1'b0;
    end else if (loading) begin
      m_qv = 1'b0;
      if (!bus_if.prog_en) begin
        loading = 1'b0; m_busy = 1'b0;
      end else if (bus_if.prog_valid) begin
        m_mem[load_idx] = bus_if.prog_data;
        if (bus_if.prog_last || load_idx == DEPTH - 1) begin
          loading = 1'b0; m_busy = 1'b0; m_done = 1'b1;
        end else begin
          load_idx++;
        end
      end
    end else if (bus_if.clr_req) begin
      clear_left = DEPTH; m_busy = 1'b1; m_qv = 1'b0;
    end else if (bus_if.prog_en) begin
      loading = 1'b1; load_idx = 0; m_busy = 1'b1; m_qv = 1'b0;
    end else if (bus_if.we) begin
      m_mem[bus_if.addr] = bus_if.data_in; m_qv = 1'b0;
    end else if (bus_if.re) begin
      m_q = m_mem[bus_if.addr]; m_qv = 1'b1;
    end else begin
      m_qv = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h req=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", {31'd0, bus_if.busy}, {31'd0, m_busy});
    chk("q_valid", {31'd0, bus_if.q_valid}, {31'd0, m_qv});
    chk("prog_done", {31'd0, bus_if.prog_done}, {31'd0, m_done});
    chk("q", {24'd0, bus_if.q}, {24'd0, m_q});
  endtask

  task automatic idle_inputs();
    bus_if.we = 1'b0; bus_if.re = 1'b0; bus_if.addr = 4'd0; bus_if.data_in = 8'h00;
    bus_if.clr_req = 1'b0; bus_if.prog_en = 1'b0; bus_if.prog_valid = 1'b0;
    bus_if.prog_data = 8'h00; bus_if.prog_last = 1'b0;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    bus_if.we = 1'b1; bus_if.addr = a; bus_if.data_in = d;
    step();
    bus_if.we = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
    bus_if.re = 1'b1; bus_if.addr = a;
    step();
    bus_if.re = 1'b0;
    chk(name, {24'd0, bus_if.q}, {24'd0, exp});
    chk({name, "_valid"}, {31'd0, bus_if.q_valid}, 32'd1);
  endtask

  typedef struct {
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [7:0] din;
    logic       exp_qv;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs [8];

  typedef struct { logic v; logic [7:0] d; logic last; } pbyte_t;
  pbyte_t stream [6];

  initial begin
    int n;
    int pulses;

    vecs[0] = '{1'b1, 1'b0, 4'd3, 8'hA5, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 4'd3, 8'h00, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 1'b0, 4'd3, 8'h00, 1'b0, 8'hA5};
    vecs[3] = '{1'b1, 1'b1, 4'd5, 8'h3C, 1'b0, 8'hA5};
    vecs[4] = '{1'b0, 1'b1, 4'd5, 8'h00, 1'b1, 8'h3C};
    vecs[5] = '{1'b1, 1'b0, 4'd5, 8'h77, 1'b0, 8'h3C};
    vecs[6] = '{1'b0, 1'b1, 4'd5, 8'h00, 1'b1, 8'h77};
    vecs[7] = '{1'b0, 1'b1, 4'd3, 8'h00, 1'b1, 8'hA5};

    stream[0] = '{1'b1, 8'h11, 1'b0};
    stream[1] = '{1'b0, 8'hDE, 1'b1};
    stream[2] = '{1'b1, 8'h22, 1'b0};
    stream[3] = '{1'b0, 8'hAD, 1'b0};
    stream[4] = '{1'b0, 8'hBE, 1'b1};
    stream[5] = '{1'b1, 8'h33, 1'b1};

    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    idle_inputs();

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_q", {24'd0, bus_if.q}, 32'h0);
    chk("rst_q_valid", {31'd0, bus_if.q_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("rst_prog_done", {31'd0, bus_if.prog_done}, 32'd0);
    rst = 1'b0;

    // Fill every word with a distinct pattern
    for (int i = 0; i < DEPTH; i++) write_word(4'(i), 8'(8'h10 + i));

    // Directed CPU vectors
    for (int i = 0; i < 8; i++) begin
      bus_if.we = vecs[i].we; bus_if.re = vecs[i].re;
      bus_if.addr = vecs[i].addr; bus_if.data_in = vecs[i].din;
      step();
      chk($sformatf("vec%0d_q_valid", i), {31'd0, bus_if.q_valid}, {31'd0, vecs[i].exp_qv});
      chk($sformatf("vec%0d_q", i), {24'd0, bus_if.q}, {24'd0, vecs[i].exp_q});
    end
    idle_inputs();

    // Clear sequence: busy for exactly DEPTH cycles, then all zero
    bus_if.clr_req = 1'b1; bus_if.we = 1'b1; bus_if.re = 1'b1; bus_if.addr = 4'd7; bus_if.data_in = 8'hEE;
    step();
    idle_inputs();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus_if.busy) break;
      n++;
      bus_if.re = 1'b1; bus_if.clr_req = 1'b1; bus_if.prog_en = 1'b1;
      step();
    end
    idle_inputs();
    chk("clear_busy_cycles", n, 32'd16);
    for (int i = 0; i < DEPTH; i++) read_chk($sformatf("clear_word%0d", i), 4'(i), 8'h00);

    // Program load with gaps and prog_last
    write_word(4'd3, 8'h99);
    bus_if.prog_en = 1'b1; bus_if.prog_valid = 1'b1; bus_if.prog_data = 8'hFF;
    step();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      bus_if.prog_valid = stream[i].v; bus_if.prog_data = stream[i].d; bus_if.prog_last = stream[i].last;
      step();
      if (bus_if.prog_done) pulses++;
    end
    chk("prog_done_at_last", {31'd0, bus_if.prog_done}, 32'd1);
    idle_inputs();
    step();
    chk("prog_done_one_cycle", {31'd0, bus_if.prog_done}, 32'd0);
    chk("prog_done_pulses", pulses, 32'd1);
    read_chk("prog_w0", 4'd0, 8'h11);
    read_chk("prog_w1", 4'd1, 8'h22);
    read_chk("prog_w2", 4'd2, 8'h33);
    read_chk("prog_w3_kept", 4'd3, 8'h99);

    // Full-depth stream without prog_last auto-completes
    bus_if.prog_en = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) begin
      bus_if.prog_valid = 1'b1; bus_if.prog_data = 8'(8'h40 + i); bus_if.prog_last = 1'b0;
      step();
    end
    chk("auto_done", {31'd0, bus_if.prog_done}, 32'd1);
    chk("auto_busy", {31'd0, bus_if.busy}, 32'd0);
    idle_inputs();
    read_chk("auto_w0_no_wrap", 4'd0, 8'h40);
    read_chk("auto_w15", 4'd15, 8'h4F);

    // Reset five cycles into a clear
    bus_if.clr_req = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {31'd0, bus_if.busy}, 32'd0);
    for (int i = 0; i < DEPTH; i++)
      read_chk($sformatf("abort_word%0d", i), 4'(i), (i < 5) ? 8'h00 : 8'(8'h40 + i));

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      bus_if.we = ($urandom % 3 == 0);
      bus_if.re = ($urandom % 2 == 0);
      bus_if.addr = 4'($urandom);
      bus_if.data_in = 8'($urandom);
      bus_if.clr_req = ($urandom % 60 == 0);
      bus_if.prog_en = loading ? ($urandom % 12 != 0) : ($urandom % 30 == 0);
      bus_if.prog_valid = ($urandom % 2 == 0);
      bus_if.prog_data = 8'($urandom);
      bus_if.prog_last = ($urandom % 6 == 0);
      step();
    end
    idle_inputs();
    n = 0;
    while (bus_if.busy && n < 40) begin
      step();
      n++;
    end
    chk("rand_settle", {31'd0, bus_if.busy}, 32'd0);
    for (int i = 0; i < DEPTH; i++) read_chk($sformatf("final_word%0d", i), 4'(i), m_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
